data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_if.sv | 27 ++
 rtl/data_memory_responder.sv | 175 +++++++++++++++++
 tb/tb_data_memory_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ============================================================================
// data_memory_responder_if : CPU load/store request and response bus
// Revision: 1.0
// ============================================================================
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// data_memory_responder : word-organised data memory answering one RISC-V
// load/store at a time after a fixed number of wait states.
// Revision: 1.0
// ============================================================================
module data_memory_responder #(
    parameter int MEM_SIZE_WORDS = 256,
    parameter int WAIT_CYCLES    = 1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    data_memory_responder_if.slave bus
);
    localparam int         IDX_W     = (MEM_SIZE_WORDS > 1) ? $clog2(MEM_SIZE_WORDS) : 1;
    localparam logic [3:0] C_WAIT    = 4'(WAIT_CYCLES);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [31:0] memory [MEM_SIZE_WORDS];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        accept;
    logic        cur_write;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        is_byte, is_half, is_word, illegal, misaligned, out_of_range, req_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0] rd_word, shifted, load_data, lane_data;
    logic [3:0]  be;
    logic        enter_respond, mem_we;

    assign accept = bus.req_valid && (state_q == S_IDLE) && reset;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live inputs stand in for the not-yet-captured request.
    always_comb begin
        cur_write  = (state_q == S_IDLE) ? bus.req_write  : write_q;
        cur_funct3 = (state_q == S_IDLE) ? bus.req_funct3 : funct3_q;
        cur_addr   = (state_q == S_IDLE) ? bus.req_addr   : addr_q;
        cur_wdata  = (state_q == S_IDLE) ? bus.req_wdata  : wdata_q;
    end

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        illegal = 1'b0;
        case (cur_funct3)
            3'b000:  is_byte = 1'b1;
            3'b001:  is_half = 1'b1;
            3'b010:  is_word = 1'b1;
            3'b100:  begin is_byte = 1'b1; illegal = cur_write; end
            3'b101:  begin is_half = 1'b1; illegal = cur_write; end
            default: illegal = 1'b1;
        endcase
        misaligned   = (is_half && cur_addr[0]) || (is_word && (cur_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(MEM_SIZE_WORDS));
        req_err      = illegal || misaligned || out_of_range;
    end

    always_comb begin
        word_idx = cur_addr[IDX_W+1:2];
        rd_word  = out_of_range ? 32'h0 : memory[word_idx];
        shifted  = rd_word >> {cur_addr[1:0], 3'b000};
        case (cur_funct3)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
        if (is_byte) begin
            be        = 4'b0001 << cur_addr[1:0];
            lane_data = {4{cur_wdata[7:0]}};
        end else if (is_half) begin
            be        = 4'b0011 << cur_addr[1:0];
            lane_data = {2{cur_wdata[15:0]}};
        end else begin
            be        = 4'b1111;
            lane_data = cur_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = C_WAIT;
                    state_d  = (C_WAIT == 4'd0) ? S_RESPOND : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESPOND;
                end
            end
            default: state_d = S_IDLE;
        endcase

        enter_respond = (state_d == S_RESPOND) && (state_q != S_RESPOND);
        mem_we        = enter_respond && cur_write && !req_err;
        rdata_d       = rdata_q;
        error_d       = error_q;
        if (enter_respond) begin
            rdata_d = (cur_write || req_err) ? 32'h0 : load_data;
            error_d = req_err;
        end
    end

    // Output logic
    always_comb begin
        bus.req_ready = (state_q == S_IDLE) && reset;
        bus.rsp_valid = (state_q == S_RESPOND);
        bus.rsp_rdata = rdata_q;
        bus.rsp_error = error_q;
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    memory[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// tb_data_memory_responder : scoreboard bench for data_memory_responder
// Revision: 1.0
// ============================================================================
module tb_data_memory_responder;
    logic clk = 1'b0;
    logic reset1, reset3, reset0;
    always #5 clk = ~clk;

    data_memory_responder_if bus1();
    data_memory_responder_if bus3();
    data_memory_responder_if bus0();

    data_memory_responder #(.MEM_SIZE_WORDS(256), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset1), .bus(bus1.slave));
    data_memory_responder #(.MEM_SIZE_WORDS(256), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .bus(bus3.slave));
    data_memory_responder #(.MEM_SIZE_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset0), .bus(bus0.slave));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rsp_cnt;
    logic [32:0] exp_q [$];
    logic [32:0] exp_rsp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every response of dut1 must match the oldest expectation.
    always @(negedge clk) begin
        if (bus1.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_rsp = exp_q.pop_front();
                check("rsp", {31'd0, bus1.rsp_error, bus1.rsp_rdata}, {31'd0, exp_rsp});
            end
        end
    end

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int guard;
        @(negedge clk);
        bus1.req_valid  = 1'b1;
        bus1.req_write  = wr;
        bus1.req_funct3 = f3;
        bus1.req_addr   = addr;
        bus1.req_wdata  = wd;
        guard = 0;
        while (bus1.req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("accept_timeout", 64'd0, 64'd1);
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        bus1.req_valid = 1'b0;
        guard = 0;
        while (bus1.rsp_valid !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("rsp_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset1 = 1'b1; reset3 = 1'b1; reset0 = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_funct3 = 3'd0;
        bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_funct3 = 3'd0;
        bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_funct3 = 3'd0;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        #2;
        reset1 = 1'b0; reset3 = 1'b0; reset0 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", bus1.rsp_valid, 1'b0);
        check("rst_rsp_rdata", bus1.rsp_rdata, 32'h0);
        check("rst_rsp_error", bus1.rsp_error, 1'b0);
        reset1 = 1'b1; reset3 = 1'b1; reset0 = 1'b1;
        @(negedge clk);
        check("ready_after_release", bus1.req_ready, 1'b1);

        // Byte/halfword extraction and extension
        do_req(1'b1, 3'b010, 32'h0, 32'h80FF7F01, 32'h0, 1'b0);
        do_req(1'b0, 3'b100, 32'h1, 32'h0, 32'h0000007F, 1'b0);
        do_req(1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req(1'b0, 3'b100, 32'h3, 32'h0, 32'h00000080, 1'b0);
        do_req(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF80FF, 1'b0);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h80FF7F01, 1'b0);

        // Partial stores
        do_req(1'b1, 3'b010, 32'h4, 32'h11223344, 32'h0, 1'b0);
        do_req(1'b1, 3'b000, 32'h6, 32'h000000AB, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'h11AB3344, 1'b0);
        do_req(1'b1, 3'b001, 32'h4, 32'h0000BEEF, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'h11ABBEEF, 1'b0);
        @(negedge clk);
        check("rdata_hold", bus1.rsp_rdata, 32'h11ABBEEF);

        // Error cases leave memory untouched
        do_req(1'b0, 3'b001, 32'h1, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 3'b010, 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 32'h80FF7F01, 1'b0);
        do_req(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
        do_req(1'b1, 3'b100, 32'h4, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req(1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h4, 32'h0, 32'h11ABBEEF, 1'b0);
        do_req(1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b0);

        // Reset during WAIT aborts the store and its response
        do_req(1'b1, 3'b010, 32'h8, 32'h0BADF00D, 32'h0, 1'b0);
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_funct3 = 3'b010;
        bus1.req_addr = 32'h8; bus1.req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("abort_in_wait", bus1.req_ready, 1'b0);
        reset1 = 1'b0;
        bus1.req_valid = 1'b0;
        rsp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            rsp_cnt += int'(bus1.rsp_valid);
        end
        reset1 = 1'b1;
        @(negedge clk);
        check("ready_after_abort", bus1.req_ready, 1'b1);
        repeat (3) begin
            rsp_cnt += int'(bus1.rsp_valid);
            @(negedge clk);
        end
        check("abort_no_rsp", rsp_cnt, 0);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, 32'h0BADF00D, 1'b0);

        // WAIT_CYCLES = 3 with req_valid held high
        @(negedge clk);
        bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_funct3 = 3'b010;
        bus3.req_addr = 32'h0;
        check("w3_ready_pre", bus3.req_ready, 1'b1);
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            check("w3_ready", bus3.req_ready, (j == 4));
            check("w3_rsp", bus3.rsp_valid, (j == 3));
        end
        bus3.req_valid = 1'b0;

        // WAIT_CYCLES = 0 back-to-back loads
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_funct3 = 3'b010;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h12345678;
        @(negedge clk);
        check("w0_sw_rsp", bus0.rsp_valid, 1'b1);
        bus0.req_valid = 1'b0;
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_write = 1'b0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("w0_ready", bus0.req_ready, (j % 2 == 1));
            check("w0_rsp", bus0.rsp_valid, (j % 2 == 0));
            if (j % 2 == 0) check("w0_rdata", bus0.rsp_rdata, 32'h12345678);
        end
        bus0.req_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
